// File: rtl/alarm_sequencer.sv
// Alarm ring sequencer: intermittent buzzer, bounded snooze, auto-timeout.
// Owns the clock's sticky Alarm flag via STOP_al while snoozing or clearing.
module alarm_sequencer #(
    parameter int unsigned SNOOZE_SEC   = 300,
    parameter int unsigned RING_TIMEOUT = 60,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       Alarm,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       STOP_al,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_cnt,
    output logic       missed,
    output logic [1:0] last_h1,
    output logic [3:0] last_h0,
    output logic [3:0] last_m1,
    output logic [3:0] last_m0
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_SEC - 1);
    localparam logic [9:0] RING_LAST = 10'(RING_TIMEOUT - 1);
    localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

    state_t     state;
    logic [9:0] ring_tmr;
    logic [9:0] snz_tmr;
    logic       snz_prev;
    logic       stp_prev;
    logic       snz_e;
    logic       stp_e;

    assign snz_e = snooze_btn & ~snz_prev;
    assign stp_e = stop_btn & ~stp_prev;

    // Button edge history, ring/snooze timers and the ring state machine.
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ring_tmr   <= '0;
            snz_tmr    <= '0;
            snz_prev   <= 1'b0;
            stp_prev   <= 1'b0;
            snooze_cnt <= '0;
            missed     <= 1'b0;
            last_h1    <= '0;
            last_h0    <= '0;
            last_m1    <= '0;
            last_m0    <= '0;
        end else begin
            snz_prev <= snooze_btn;
            stp_prev <= stop_btn;
            case (state)
                IDLE: begin
                    if (Alarm) begin
                        state      <= RING;
                        last_h1    <= H_out1;
                        last_h0    <= H_out0;
                        last_m1    <= M_out1;
                        last_m0    <= M_out0;
                        ring_tmr   <= '0;
                        missed     <= 1'b0;
                        snooze_cnt <= '0;
                    end else if (stp_e) begin
                        missed <= 1'b0;
                    end
                end
                RING: begin
                    ring_tmr <= ring_tmr + 10'd1;
                    if (stp_e) begin
                        state <= CLEAR;
                    end else if (snz_e && (snooze_cnt < SNZ_MAX)) begin
                        state      <= SNOOZE;
                        snooze_cnt <= snooze_cnt + 3'd1;
                        snz_tmr    <= SNZ_LOAD;
                    end else if (ring_tmr == RING_LAST) begin
                        state  <= CLEAR;
                        missed <= 1'b1;
                    end
                end
                SNOOZE: begin
                    if (snz_tmr != 10'd0) begin
                        snz_tmr <= snz_tmr - 10'd1;
                    end
                    if (stp_e) begin
                        state <= CLEAR;
                    end else if (snz_tmr == 10'd0) begin
                        state    <= RING;
                        ring_tmr <= '0;
                    end
                end
                CLEAR: begin
                    if (!Alarm) begin
                        state      <= IDLE;
                        snooze_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign STOP_al  = (state == SNOOZE) || (state == CLEAR);
    assign buzzer   = (state == RING) && !ring_tmr[0];
    assign ringing  = (state == RING);
    assign snoozing = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer with a behavioural model of the
// clock's sticky Alarm flag (cleared one edge after STOP_al is seen).
module tb_alarm_sequencer;

    logic       clk_1s = 1'b0;
    logic       reset;
    logic       Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0;
    logic [3:0] M_out1;
    logic [3:0] M_out0;
    logic       snooze_btn;
    logic       stop_btn;
    logic       STOP_al;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [2:0] snooze_cnt;
    logic       missed;
    logic [1:0] last_h1;
    logic [3:0] last_h0;
    logic [3:0] last_m1;
    logic [3:0] last_m0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb[$];

    wire [7:0]  o  = {STOP_al, buzzer, ringing, snoozing, snooze_cnt, missed};
    wire [13:0] lt = {last_h1, last_h0, last_m1, last_m0};

    alarm_sequencer #(
        .SNOOZE_SEC  (5),
        .RING_TIMEOUT(8),
        .MAX_SNOOZE  (2)
    ) dut (
        .clk_1s    (clk_1s),
        .reset     (reset),
        .Alarm     (Alarm),
        .H_out1    (H_out1),
        .H_out0    (H_out0),
        .M_out1    (M_out1),
        .M_out0    (M_out0),
        .snooze_btn(snooze_btn),
        .stop_btn  (stop_btn),
        .STOP_al   (STOP_al),
        .buzzer    (buzzer),
        .ringing   (ringing),
        .snoozing  (snoozing),
        .snooze_cnt(snooze_cnt),
        .missed    (missed),
        .last_h1   (last_h1),
        .last_h0   (last_h0),
        .last_m1   (last_m1),
        .last_m0   (last_m0)
    );

    always #5 clk_1s = ~clk_1s;

    // step word: {raise_alarm, snooze_lvl, stop_lvl, expected_outputs[7:0]}
    function automatic logic [10:0] mk(input logic al, input logic snz,
                                       input logic stp, input logic [7:0] e);
        return {al, snz, stp, e};
    endfunction

    task automatic set_time(input logic [1:0] h1, input logic [3:0] h0,
                            input logic [3:0] m1, input logic [3:0] m0);
        H_out1 = h1;
        H_out0 = h0;
        M_out1 = m1;
        M_out0 = m0;
    endtask

    // Drive one step at a negedge, queue its expectation, advance one edge.
    task automatic apply(input logic [10:0] s);
        logic stop_before;
        stop_before = STOP_al;
        if (s[10]) Alarm = 1'b1;
        snooze_btn = s[9];
        stop_btn   = s[8];
        sb.push_back(s[7:0]);
        @(posedge clk_1s);
        @(negedge clk_1s);
        if (stop_before) Alarm = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset = 1'b1;
        Alarm = 1'b0;
        snooze_btn = 1'b0;
        stop_btn = 1'b0;
        set_time(2'd0, 4'd0, 4'd0, 4'd0);
        #2;
        sb.push_back(8'h00);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL reset_out: got %h want %h", o, e);
        end
        n_cmp++;
        if (lt !== 14'd0) begin
            n_err++;
            $display("FAIL reset_last: got %h want 0", lt);
        end
        @(negedge clk_1s);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [10:0] t[$];
        logic [7:0]  e;
        logic [13:0] want;
        set_time(2'd0, 4'd7, 4'd3, 4'd0);
        for (int i = 1; i <= 9; i++) t.push_back(mk(0, 0, 0, 8'h00));
        t.push_back(mk(1, 0, 0, 8'h60));
        t.push_back(mk(0, 0, 0, 8'h20));
        t.push_back(mk(0, 0, 0, 8'h60));
        t.push_back(mk(0, 0, 1, 8'h80));
        t.push_back(mk(0, 0, 0, 8'h80));
        t.push_back(mk(0, 0, 0, 8'h00));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL basic[edge %0d]: got %h want %h", i + 1, o, e);
            end
        end
        want = {2'd0, 4'd7, 4'd3, 4'd0};
        n_cmp++;
        if (lt !== want) begin
            n_err++;
            $display("FAIL basic_last: got %h want %h", lt, want);
        end
    endtask

    task automatic test_snooze();
        logic [10:0] t[$];
        logic [7:0]  e;
        logic [13:0] want;
        set_time(2'd0, 4'd6, 4'd4, 4'd5);
        t.push_back(mk(1, 0, 0, 8'h60));
        t.push_back(mk(0, 0, 0, 8'h20));
        t.push_back(mk(0, 1, 0, 8'h92));
        for (int i = 0; i < 4; i++) t.push_back(mk(0, 0, 0, 8'h92));
        t.push_back(mk(0, 0, 0, 8'h62));
        t.push_back(mk(0, 0, 1, 8'h82));
        t.push_back(mk(0, 0, 0, 8'h00));
        foreach (t[i]) begin
            if (i == 1) set_time(2'd0, 4'd6, 4'd5, 4'd0);
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL snooze[%0d]: got %h want %h", i, o, e);
            end
        end
        want = {2'd0, 4'd6, 4'd4, 4'd5};
        n_cmp++;
        if (lt !== want) begin
            n_err++;
            $display("FAIL snooze_last: got %h want %h", lt, want);
        end
    endtask

    task automatic test_limit();
        logic [10:0] t[$];
        logic [7:0]  e;
        t.push_back(mk(1, 0, 0, 8'h60));
        t.push_back(mk(0, 1, 0, 8'h92));
        for (int i = 0; i < 4; i++) t.push_back(mk(0, 0, 0, 8'h92));
        t.push_back(mk(0, 0, 0, 8'h62));
        t.push_back(mk(0, 1, 0, 8'h94));
        for (int i = 0; i < 4; i++) t.push_back(mk(0, 0, 0, 8'h94));
        t.push_back(mk(0, 0, 0, 8'h64));
        t.push_back(mk(0, 1, 0, 8'h24));
        t.push_back(mk(0, 0, 0, 8'h64));
        t.push_back(mk(0, 0, 0, 8'h24));
        t.push_back(mk(0, 0, 0, 8'h64));
        t.push_back(mk(0, 0, 0, 8'h24));
        t.push_back(mk(0, 0, 0, 8'h64));
        t.push_back(mk(0, 0, 0, 8'h24));
        t.push_back(mk(0, 0, 0, 8'h85));
        t.push_back(mk(0, 0, 0, 8'h01));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL limit[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [10:0] t[$];
        logic [7:0]  e;
        t.push_back(mk(1, 0, 0, 8'h60));
        t.push_back(mk(0, 1, 0, 8'h92));
        for (int i = 0; i < 4; i++) t.push_back(mk(0, 0, 0, 8'h92));
        t.push_back(mk(0, 0, 0, 8'h62));
        t.push_back(mk(1, 1, 1, 8'h82));
        t.push_back(mk(0, 0, 0, 8'h82));
        t.push_back(mk(0, 0, 0, 8'h00));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL simul[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_held_ack();
        logic [10:0] t[$];
        logic [7:0]  e;
        t.push_back(mk(0, 0, 1, 8'h00));
        t.push_back(mk(1, 0, 1, 8'h60));
        t.push_back(mk(0, 0, 1, 8'h20));
        t.push_back(mk(0, 0, 0, 8'h60));
        t.push_back(mk(0, 0, 1, 8'h80));
        t.push_back(mk(0, 0, 0, 8'h80));
        t.push_back(mk(0, 0, 0, 8'h00));
        t.push_back(mk(1, 0, 0, 8'h60));
        for (int i = 0; i < 3; i++) begin
            t.push_back(mk(0, 0, 0, 8'h20));
            t.push_back(mk(0, 0, 0, 8'h60));
        end
        t.push_back(mk(0, 0, 0, 8'h20));
        t.push_back(mk(0, 0, 0, 8'h81));
        t.push_back(mk(0, 0, 0, 8'h81));
        t.push_back(mk(0, 0, 0, 8'h01));
        t.push_back(mk(0, 0, 1, 8'h00));
        t.push_back(mk(0, 0, 0, 8'h00));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL held[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] t[$];
        logic [7:0]  e;
        set_time(2'd1, 4'd2, 4'd1, 4'd5);
        t.push_back(mk(1, 0, 0, 8'h60));
        t.push_back(mk(0, 1, 0, 8'h92));
        t.push_back(mk(0, 0, 0, 8'h92));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rstmid[%0d]: got %h want %h", i, o, e);
            end
        end
        Alarm = 1'b1;
        snooze_btn = 1'b0;
        reset = 1'b1;
        #1;
        sb.push_back(8'h00);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL rstmid_async: got %h want %h", o, e);
        end
        n_cmp++;
        if (lt !== 14'd0) begin
            n_err++;
            $display("FAIL rstmid_last: got %h want 0", lt);
        end
        #2;
        reset = 1'b0;
        apply(mk(1, 0, 0, 8'h60));
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL rstmid_ring: got %h want %h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snooze();
        test_limit();
        test_simultaneous();
        test_held_ack();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
